// File: rtl/v_haar_stage_evaluator.sv
// rtl/v_haar_stage_evaluator.sv - Haar cascade stage evaluator: leaf selection, stage sum and pass/fail decision
module v_haar_stage_evaluator #(
    parameter int DATA_WIDTH_12            = 12,
    parameter int DATA_WIDTH_16            = 16,
    parameter int ACC_WIDTH                = 20,
    parameter int NUM_PARAM_PER_CLASSIFIER = 19,
    parameter int NUM_STAGE_THRESHOLD      = 3,
    parameter int NUM_CLASSIFIERS          = 32,
    parameter int THR_OFFSET               = 15
) (
    input  logic                     clk_fpga,
    input  logic                     reset_fpga,
    input  logic                     i_start,
    output logic                     o_rden,
    input  logic                     i_db_valid,
    input  logic [DATA_WIDTH_12-1:0] i_db_data,
    input  logic                     i_feature_valid,
    input  logic [DATA_WIDTH_16-1:0] i_feature_value,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_pass,
    output logic [ACC_WIDTH-1:0]     o_stage_sum,
    output logic                     o_error
);

    // One counter serves both the classifier records and the trailing stage words.
    localparam int WORD_MAX = (NUM_PARAM_PER_CLASSIFIER > NUM_STAGE_THRESHOLD) ?
                              NUM_PARAM_PER_CLASSIFIER : NUM_STAGE_THRESHOLD;
    localparam int WORD_W   = (WORD_MAX > 1) ? $clog2(WORD_MAX) : 1;
    localparam int CLS_W    = (NUM_CLASSIFIERS > 1) ? $clog2(NUM_CLASSIFIERS) : 1;

    localparam logic [WORD_W-1:0] W_NODE_THR   = WORD_W'(THR_OFFSET);
    localparam logic [WORD_W-1:0] W_LEAF_L     = WORD_W'(THR_OFFSET + 1);
    localparam logic [WORD_W-1:0] W_LEAF_R     = WORD_W'(THR_OFFSET + 2);
    localparam logic [WORD_W-1:0] W_LAST_PARAM = WORD_W'(NUM_PARAM_PER_CLASSIFIER - 1);
    localparam logic [WORD_W-1:0] W_LAST_STAGE = WORD_W'(NUM_STAGE_THRESHOLD - 1);
    localparam logic [CLS_W-1:0]  C_LAST       = CLS_W'(NUM_CLASSIFIERS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_FEAT,
        S_ACCUM,
        S_LOAD_THR,
        S_DECIDE
    } state_t;

    state_t                   state_q, state_d;
    logic [WORD_W-1:0]        word_cnt_q, word_cnt_d;
    logic [CLS_W-1:0]         cls_cnt_q, cls_cnt_d;
    logic [DATA_WIDTH_12-1:0] node_thr_q, node_thr_d;
    logic [DATA_WIDTH_12-1:0] leaf_l_q, leaf_l_d;
    logic [DATA_WIDTH_12-1:0] leaf_r_q, leaf_r_d;
    logic [DATA_WIDTH_12-1:0] stage_thr_q, stage_thr_d;
    logic [DATA_WIDTH_16-1:0] feat_q, feat_d;
    logic                     pend_q, pend_d;
    logic [ACC_WIDTH-1:0]     acc_q, acc_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     pass_q, pass_d;
    logic [ACC_WIDTH-1:0]     sum_q, sum_d;
    logic                     error_q, error_d;

    // Sign-extended views of the 12-bit database fields.
    logic [DATA_WIDTH_16-1:0] node_thr_ext;
    logic [ACC_WIDTH-1:0]     leaf_l_ext;
    logic [ACC_WIDTH-1:0]     leaf_r_ext;
    logic [ACC_WIDTH-1:0]     stage_thr_ext;
    logic                     take_left;

    assign node_thr_ext  = {{(DATA_WIDTH_16 - DATA_WIDTH_12){node_thr_q[DATA_WIDTH_12-1]}}, node_thr_q};
    assign leaf_l_ext    = {{(ACC_WIDTH - DATA_WIDTH_12){leaf_l_q[DATA_WIDTH_12-1]}}, leaf_l_q};
    assign leaf_r_ext    = {{(ACC_WIDTH - DATA_WIDTH_12){leaf_r_q[DATA_WIDTH_12-1]}}, leaf_r_q};
    assign stage_thr_ext = {{(ACC_WIDTH - DATA_WIDTH_12){stage_thr_q[DATA_WIDTH_12-1]}}, stage_thr_q};
    // A feature equal to the node threshold falls to the right leaf.
    assign take_left     = $signed(feat_q) < $signed(node_thr_ext);

    // Next-state logic: sequencing, feature capture, accumulation and decision.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        cls_cnt_d   = cls_cnt_q;
        node_thr_d  = node_thr_q;
        leaf_l_d    = leaf_l_q;
        leaf_r_d    = leaf_r_q;
        stage_thr_d = stage_thr_q;
        feat_d      = feat_q;
        pend_d      = pend_q;
        acc_d       = acc_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        sum_d       = sum_q;
        error_d     = error_q;

        // A start outside IDLE is a protocol violation and does not restart.
        if (i_start && (state_q != S_IDLE)) begin
            error_d = 1'b1;
        end

        // Feature capture runs alongside the database sequencing; a second
        // response before the first is consumed is dropped and flagged.
        if (busy_q && i_feature_valid) begin
            if (!pend_q) begin
                feat_d = i_feature_value;
                pend_d = 1'b1;
            end else begin
                error_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d    = S_LOAD;
                    acc_d      = '0;
                    word_cnt_d = '0;
                    cls_cnt_d  = '0;
                    pend_d     = 1'b0;
                    pass_d     = 1'b0;
                    sum_d      = '0;
                    error_d    = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            S_LOAD: begin
                if (i_db_valid) begin
                    if (word_cnt_q == W_NODE_THR) node_thr_d = i_db_data;
                    if (word_cnt_q == W_LEAF_L)   leaf_l_d   = i_db_data;
                    if (word_cnt_q == W_LEAF_R)   leaf_r_d   = i_db_data;
                    if (word_cnt_q == W_LAST_PARAM) begin
                        word_cnt_d = '0;
                        state_d    = pend_q ? S_ACCUM : S_WAIT_FEAT;
                    end else begin
                        word_cnt_d = word_cnt_q + WORD_W'(1);
                    end
                end
            end

            S_WAIT_FEAT: begin
                if (pend_q) begin
                    state_d = S_ACCUM;
                end
            end

            S_ACCUM: begin
                acc_d  = acc_q + (take_left ? leaf_l_ext : leaf_r_ext);
                pend_d = 1'b0;
                if (cls_cnt_q == C_LAST) begin
                    cls_cnt_d = '0;
                    state_d   = S_LOAD_THR;
                end else begin
                    cls_cnt_d = cls_cnt_q + CLS_W'(1);
                    state_d   = S_LOAD;
                end
            end

            S_LOAD_THR: begin
                if (i_db_valid) begin
                    if (word_cnt_q == '0) stage_thr_d = i_db_data;
                    if (word_cnt_q == W_LAST_STAGE) begin
                        word_cnt_d = '0;
                        state_d    = S_DECIDE;
                    end else begin
                        word_cnt_d = word_cnt_q + WORD_W'(1);
                    end
                end
            end

            S_DECIDE: begin
                pass_d  = $signed(acc_q) >= $signed(stage_thr_ext);
                sum_d   = acc_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (pend_q) error_d = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset aborts any evaluation.
    always_ff @(posedge clk_fpga) begin
        if (!reset_fpga) begin
            state_q     <= S_IDLE;
            word_cnt_q  <= '0;
            cls_cnt_q   <= '0;
            node_thr_q  <= '0;
            leaf_l_q    <= '0;
            leaf_r_q    <= '0;
            stage_thr_q <= '0;
            feat_q      <= '0;
            pend_q      <= 1'b0;
            acc_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            sum_q       <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            cls_cnt_q   <= cls_cnt_d;
            node_thr_q  <= node_thr_d;
            leaf_l_q    <= leaf_l_d;
            leaf_r_q    <= leaf_r_d;
            stage_thr_q <= stage_thr_d;
            feat_q      <= feat_d;
            pend_q      <= pend_d;
            acc_q       <= acc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            sum_q       <= sum_d;
            error_q     <= error_d;
        end
    end

    assign o_rden      = (state_q == S_LOAD) || (state_q == S_LOAD_THR);
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_pass      = pass_q;
    assign o_stage_sum = sum_q;
    assign o_error     = error_q;

endmodule

// File: tb/tb_v_haar_stage_evaluator.sv
// tb/tb_v_haar_stage_evaluator.sv - directed vector bench for v_haar_stage_evaluator
module tb_v_haar_stage_evaluator;

    logic        clk_fpga = 1'b0;
    logic        reset_fpga;
    logic        i_start;
    logic        o_rden;
    logic        i_db_valid;
    logic [11:0] i_db_data;
    logic        i_feature_valid;
    logic [15:0] i_feature_value;
    logic        o_busy;
    logic        o_done;
    logic        o_pass;
    logic [19:0] o_stage_sum;
    logic        o_error;

    int tests = 0;
    int fails = 0;

    logic [11:0] node_thr = 12'd100;
    logic [11:0] leaf_l [2];
    logic [11:0] leaf_r [2];
    logic [11:0] cur_st;

    always #5 clk_fpga = ~clk_fpga;

    v_haar_stage_evaluator #(
        .NUM_CLASSIFIERS(2)
    ) dut (
        .clk_fpga       (clk_fpga),
        .reset_fpga     (reset_fpga),
        .i_start        (i_start),
        .o_rden         (o_rden),
        .i_db_valid     (i_db_valid),
        .i_db_data      (i_db_data),
        .i_feature_valid(i_feature_valid),
        .i_feature_value(i_feature_value),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_pass         (o_pass),
        .o_stage_sum    (o_stage_sum),
        .o_error        (o_error)
    );

    typedef struct {
        string       name;
        logic [15:0] f0;
        int          f0_at;
        int          f0_late;
        logic [15:0] f1;
        int          f1_at;
        int          f1_late;
        int          dup_at;
        logic [15:0] dup_v;
        int          start_at;
        logic [11:0] st;
        logic        exp_pass;
        logic [19:0] exp_sum;
        logic        exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic step();
        @(posedge clk_fpga);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] rec_word(input int c, input int k);
        logic [11:0] w;
        if (c == 2) begin
            w = (k == 0) ? cur_st : 12'h5A5;
        end else begin
            case (k)
                15:      w = node_thr;
                16:      w = leaf_l[c];
                17:      w = leaf_r[c];
                default: w = 12'(16 * c + k);
            endcase
        end
        return w;
    endfunction

    function automatic int exp_gap(input int f_at, input int late);
        return (f_at >= 0) ? 1 : late + 3;
    endfunction

    // Present n words whenever o_rden is high, with optional side pulses at given word indices.
    task automatic feed(input string name, input int c, input int n, input int f_at, input logic [15:0] fv,
                        input int dup_at, input logic [15:0] dv, input int st_at);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 100) begin
            i_feature_valid = 1'b0;
            i_start         = 1'b0;
            if (o_rden) begin
                i_db_valid = 1'b1;
                i_db_data  = rec_word(c, k);
                if (k == f_at)   begin i_feature_valid = 1'b1; i_feature_value = fv; end
                if (k == dup_at) begin i_feature_valid = 1'b1; i_feature_value = dv; end
                if (k == st_at)  i_start = 1'b1;
                k++;
            end else begin
                i_db_valid = 1'b1;
                i_db_data  = 12'h7FF;
            end
            step();
            guard++;
        end
        i_db_valid      = 1'b0;
        i_feature_valid = 1'b0;
        i_start         = 1'b0;
        check({name, "_words_taken"}, k, n);
    endtask

    // Count o_rden-low cycles (junk words offered) and optionally deliver a late feature.
    task automatic gap_wait(input int delay, input logic [15:0] fv, output int gap);
        gap = 0;
        while (!o_rden && gap < 100) begin
            gap++;
            i_db_valid      = 1'b1;
            i_db_data       = 12'h7FF;
            i_feature_valid = (delay >= 0) && (gap == delay + 1);
            i_feature_value = fv;
            step();
        end
        i_db_valid      = 1'b0;
        i_feature_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int g;
        int lat;
        cur_st  = v.st;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check({v.name, "_busy_after_start"}, o_busy, 1);
        check({v.name, "_err_cleared"}, o_error, 0);
        check({v.name, "_sum_cleared"}, o_stage_sum, 0);
        check({v.name, "_rden_load"}, o_rden, 1);

        feed({v.name, "_c0"}, 0, 19, v.f0_at, v.f0, v.dup_at, v.dup_v, v.start_at);
        gap_wait((v.f0_at >= 0) ? -1 : v.f0_late, v.f0, g);
        check({v.name, "_gap_c0"}, g, exp_gap(v.f0_at, v.f0_late));

        feed({v.name, "_c1"}, 1, 19, v.f1_at, v.f1, -1, 16'd0, -1);
        gap_wait((v.f1_at >= 0) ? -1 : v.f1_late, v.f1, g);
        check({v.name, "_gap_c1"}, g, exp_gap(v.f1_at, v.f1_late));

        feed({v.name, "_stage"}, 2, 3, -1, 16'd0, -1, 16'd0, -1);
        lat = 1;
        while (!o_done && lat < 20) begin
            step();
            lat++;
        end
        check({v.name, "_done_latency"}, lat, 2);
        check({v.name, "_done"}, o_done, 1);
        check({v.name, "_busy_at_done"}, o_busy, 0);
        check({v.name, "_pass"}, o_pass, v.exp_pass);
        check({v.name, "_sum"}, o_stage_sum, v.exp_sum);
        check({v.name, "_error"}, o_error, v.exp_err);
        step();
        check({v.name, "_done_one_cycle"}, o_done, 0);
        check({v.name, "_pass_held"}, o_pass, v.exp_pass);
        check({v.name, "_sum_held"}, o_stage_sum, v.exp_sum);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g;
        int seen_done;

        leaf_l[0] = 12'd5;
        leaf_r[0] = 12'hFFD;
        leaf_l[1] = 12'd7;
        leaf_r[1] = 12'd2;

        //        name          f0        at lt f1        at lt dup dupv    sta st       pass sum        err
        vecs[0] = '{"pass",      16'd50,   3, 0, 16'd150,   3, 0, -1, 16'd0,   -1, 12'd6,   1'b1, 20'd7,     1'b0};
        vecs[1] = '{"fail_neg",  16'd200,  3, 0, 16'd200,   3, 0, -1, 16'd0,   -1, 12'd0,   1'b0, 20'hFFFFF, 1'b0};
        vecs[2] = '{"late_feat", 16'd50,  -1, 5, 16'd150,   3, 0, -1, 16'd0,   -1, 12'd7,   1'b1, 20'd7,     1'b0};
        vecs[3] = '{"equal_thr", 16'd100,  3, 0, 16'd100,  -1, 2, -1, 16'd0,   -1, 12'hFFF, 1'b1, 20'hFFFFF, 1'b0};
        vecs[4] = '{"dup_feat",  16'd50,   3, 0, 16'd150,   3, 0,  6, 16'd200, -1, 12'd8,   1'b0, 20'd7,     1'b1};
        vecs[5] = '{"neg_feat",  16'hFFFB, 3, 0, 16'h8000,  3, 0, -1, 16'd0,   -1, 12'd12,  1'b1, 20'd12,    1'b0};
        vecs[6] = '{"start_busy",16'd50,   3, 0, 16'd150,   3, 0, -1, 16'd0,   10, 12'd6,   1'b1, 20'd7,     1'b1};

        reset_fpga      = 1'b0;
        i_start         = 1'b0;
        i_db_valid      = 1'b0;
        i_db_data       = 12'd0;
        i_feature_valid = 1'b0;
        i_feature_value = 16'd0;
        cur_st          = 12'd0;
        repeat (3) step();
        reset_fpga = 1'b1;
        step();
        check("reset_rden", o_rden, 0);
        check("reset_busy", o_busy, 0);
        check("reset_done", o_done, 0);
        check("reset_pass", o_pass, 0);
        check("reset_sum", o_stage_sum, 0);
        check("reset_error", o_error, 0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
            repeat (2) step();
        end

        // Abort mid-record: reset arrives where c1 word 7 would be accepted.
        cur_st  = 12'd6;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        feed("abort_c0", 0, 19, 3, 16'd50, -1, 16'd0, -1);
        gap_wait(-1, 16'd0, g);
        feed("abort_c1", 1, 7, -1, 16'd0, -1, 16'd0, -1);
        check("abort_still_busy", o_busy, 1);
        reset_fpga = 1'b0;
        i_db_valid = 1'b1;
        i_db_data  = rec_word(1, 7);
        step();
        i_db_valid = 1'b0;
        reset_fpga = 1'b1;
        check("abort_busy", o_busy, 0);
        check("abort_done", o_done, 0);
        check("abort_rden", o_rden, 0);
        check("abort_pass", o_pass, 0);
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (o_done) seen_done++;
            step();
        end
        check("abort_no_done", seen_done, 0);
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
